// File: rtl/enq_pkt_desc_deq.sv
// Dequeue stage for the enqueue packet-descriptor FIFO.
// Pops descriptors from a FIFO with a one-cycle registered read latency,
// lands them in a 4-entry flop buffer and presents the buffer head to the
// downstream scheduler on a valid/ready interface at full throughput.
// Also counts captured descriptors (silent wrap) for diagnostics.
module enq_pkt_desc_deq #(
  parameter int CNT_NBITS = 32,
  parameter int DATA_W    = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 deq_en,
  input  logic                 fifo_empty,
  input  logic [DATA_W-1:0]    fifo_dout,
  output logic                 fifo_rd,
  output logic                 desc_valid,
  output logic [DATA_W-1:0]    desc,
  input  logic                 desc_ready,
  output logic [2:0]           buf_count,
  output logic [CNT_NBITS-1:0] deq_count
);

  localparam logic [CNT_NBITS-1:0] CNT_ONE = {{(CNT_NBITS-1){1'b0}}, 1'b1};

  logic [DATA_W-1:0]    r_buf [4];
  logic [1:0]           r_wptr;
  logic [1:0]           r_rptr;
  logic [2:0]           r_buf_count;
  logic                 r_pend;
  logic [CNT_NBITS-1:0] r_deq_count;

  logic [3:0]           w_fill;
  logic                 w_pop;
  logic [2:0]           w_buf_count_nxt;

  // Space check counts the pop already in flight; a same-cycle drain from
  // the buffer is deliberately ignored so fifo_rd never sees desc_ready.
  assign w_fill     = {1'b0, r_buf_count} + {3'b000, r_pend};
  assign fifo_rd    = ~rst & deq_en & ~fifo_empty & (w_fill < 4'd4);

  assign desc_valid = (r_buf_count != 3'd0);
  assign desc       = r_buf[r_rptr];
  assign w_pop      = desc_valid & desc_ready;

  assign buf_count  = r_buf_count;
  assign deq_count  = r_deq_count;

  // Next occupancy: +1 on capture, -1 on handshake, unchanged for both.
  always_comb begin
    w_buf_count_nxt = r_buf_count;
    unique case ({r_pend, w_pop})
      2'b10:   w_buf_count_nxt = r_buf_count + 3'd1;
      2'b01:   w_buf_count_nxt = r_buf_count - 3'd1;
      default: w_buf_count_nxt = r_buf_count;
    endcase
  end

  // Control state: in-flight pop flag, ring pointers, occupancy, counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend      <= 1'b0;
      r_wptr      <= 2'd0;
      r_rptr      <= 2'd0;
      r_buf_count <= 3'd0;
      r_deq_count <= '0;
    end else begin
      r_pend      <= fifo_rd;
      r_buf_count <= w_buf_count_nxt;
      if (r_pend) begin
        r_wptr      <= r_wptr + 2'd1;
        r_deq_count <= r_deq_count + CNT_ONE;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 2'd1;
      end
    end
  end

  // Descriptor storage: capture FIFO read data the cycle after the pop.
  always_ff @(posedge clk) begin
    if (r_pend) begin
      r_buf[r_wptr] <= fifo_dout;
    end
  end

endmodule

// File: tb/tb_enq_pkt_desc_deq.sv
// Scoreboard bench for enq_pkt_desc_deq with a behavioural FIFO model.
module tb_enq_pkt_desc_deq;

  localparam int DW = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          deq_en = 1'b0;
  logic          fifo_empty = 1'b1;
  logic [DW-1:0] fifo_dout = '0;
  logic          fifo_rd;
  logic          desc_valid;
  logic [DW-1:0] desc;
  logic          desc_ready = 1'b0;
  logic [2:0]    buf_count;
  logic [CW-1:0] deq_count;

  always #5 clk = ~clk;

  enq_pkt_desc_deq #(.CNT_NBITS(CW), .DATA_W(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .deq_en     (deq_en),
    .fifo_empty (fifo_empty),
    .fifo_dout  (fifo_dout),
    .fifo_rd    (fifo_rd),
    .desc_valid (desc_valid),
    .desc       (desc),
    .desc_ready (desc_ready),
    .buf_count  (buf_count),
    .deq_count  (deq_count)
  );

  int            n_tests = 0;
  int            n_fail  = 0;
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];
  bit            rd_smp = 0;
  bit            pend_m = 0;
  int            n_cap = 0;
  int            n_del = 0;
  int            rd_seen = 0;
  bit            hold_prev = 0;
  logic [DW-1:0] hold_desc = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic push(input logic [DW-1:0] d);
    fifo_q.push_back(d);
    exp_q.push_back(d);
    fifo_empty = 1'b0;
  endtask

  // Advance one clock: FIFO model returns popped data one cycle after fifo_rd.
  task automatic step();
    @(posedge clk);
    #1;
    if (pend_m) n_cap++;
    pend_m = rd_smp;
    if (rd_smp && fifo_q.size() > 0) fifo_dout = fifo_q.pop_front();
    rd_smp = 0;
    fifo_empty = (fifo_q.size() == 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_fifo_rd", fifo_rd, 0);
    check("rst_desc_valid", desc_valid, 0);
    check("rst_buf_count", buf_count, 0);
    check("rst_deq_count", deq_count, 0);
    fifo_q.delete();
    exp_q.delete();
    n_cap = 0; n_del = 0; pend_m = 0; rd_smp = 0; hold_prev = 0;
    fifo_empty = 1'b1; deq_en = 1'b0; desc_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  // Monitor: checks every output cycle against the reference model.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        check("rd_while_empty", fifo_rd & fifo_empty, 0);
        check("buf_le4", (buf_count <= 3'd4), 1);
        check("buf_count", buf_count, n_cap - n_del);
        check("deq_count", deq_count, n_cap % 16);
        if (hold_prev) begin
          check("hold_valid", desc_valid, 1);
          check("hold_desc", desc, hold_desc);
        end
        if (desc_valid && desc_ready) begin
          if (exp_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL unexpected_desc: got %0h expected none", desc);
          end else begin
            check("desc_order", desc, exp_q.pop_front());
          end
          n_del++;
        end
        hold_prev = desc_valid && !desc_ready;
        hold_desc = desc;
        if (fifo_rd) rd_seen++;
      end else begin
        hold_prev = 0;
      end
      rd_smp = fifo_rd & ~rst;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] d0;
    bit            rd_hist[24];
    bit            val_hist[24];
    int            ones, runs, cyc, bias;
    bit            found;

    #1;
    do_reset();

    // Single entry latency.
    deq_en = 1'b1; desc_ready = 1'b1;
    step();
    d0 = $urandom;
    push(d0);
    @(negedge clk); check("t1_rd", fifo_rd, 1);
    step(); @(negedge clk); check("t1_valid_early", desc_valid, 0);
    step(); @(negedge clk); check("t1_valid", desc_valid, 1); check("t1_desc", desc, d0);
    step(); @(negedge clk);
    check("t1_drained", desc_valid, 0);
    check("t1_buf", buf_count, 0);
    check("t1_deq_count", deq_count, 1);
    step();

    // Burst of 16 at full throughput.
    do_reset();
    desc_ready = 1'b1;
    step();
    for (int i = 0; i < 16; i++) push($urandom);
    deq_en = 1'b1;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      rd_hist[i] = fifo_rd;
      val_hist[i] = desc_valid;
      step();
    end
    ones = 0; runs = 0;
    for (int i = 0; i < 24; i++) begin
      ones += rd_hist[i];
      if (rd_hist[i] && (i == 0 || !rd_hist[i-1])) runs++;
    end
    check("t2_rd_cycles", ones, 16);
    check("t2_rd_runs", runs, 1);
    ones = 0; runs = 0;
    for (int i = 0; i < 24; i++) begin
      ones += val_hist[i];
      if (val_hist[i] && (i == 0 || !val_hist[i-1])) runs++;
    end
    check("t2_valid_cycles", ones, 16);
    check("t2_valid_runs", runs, 1);
    check("t2_drained", exp_q.size(), 0);

    // Backpressure: only four pops, head held stable.
    do_reset();
    step();
    d0 = $urandom;
    push(d0);
    for (int i = 1; i < 10; i++) push($urandom);
    deq_en = 1'b1;
    rd_seen = 0;
    repeat (20) step();
    check("t3_pops", rd_seen, 4);
    @(negedge clk);
    check("t3_buf_full", buf_count, 4);
    check("t3_valid", desc_valid, 1);
    check("t3_head", desc, d0);
    step();
    desc_ready = 1'b1;
    repeat (20) step();
    check("t3_drained", exp_q.size(), 0);
    check("t3_delivered", n_del, 10);

    // Random deq_en / desc_ready with 1000 descriptors.
    do_reset();
    cyc = 0; bias = 50;
    begin
      int pushed;
      pushed = 0;
      while ((pushed < 1000 || exp_q.size() > 0) && cyc < 20000) begin
        step();
        cyc++;
        if (cyc % 200 == 0) bias = (bias == 50) ? 90 : ((bias == 90) ? 20 : 50);
        deq_en = ($urandom % 4) != 0;
        desc_ready = ($urandom % 100) < bias;
        if (pushed < 1000 && ($urandom % 3) != 0) begin
          push($urandom); pushed++;
          if (pushed < 1000 && ($urandom % 2) != 0) begin push($urandom); pushed++; end
        end
      end
    end
    check("t4_completed", exp_q.size(), 0);
    check("t4_delivered", n_del, 1000);
    check("t4_deq_count", deq_count, 8);

    // Reset mid-stream with a pop in flight and three buffered.
    do_reset();
    step();
    for (int i = 0; i < 10; i++) push($urandom);
    deq_en = 1'b1;
    found = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (buf_count == 3'd3) begin found = 1; break; end
      step();
    end
    check("t5_reached_3", found, 1);
    #2;
    do_reset();
    deq_en = 1'b1; desc_ready = 1'b1;
    d0 = $urandom;
    push(d0);
    push($urandom);
    push($urandom);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (desc_valid) break;
      step();
    end
    check("t5_valid", desc_valid, 1);
    check("t5_new_head", desc, d0);
    repeat (10) step();
    check("t5_drained", exp_q.size(), 0);

    // Counter wrap: 17 captures in a 4-bit counter.
    do_reset();
    deq_en = 1'b1; desc_ready = 1'b1;
    step();
    for (int i = 0; i < 17; i++) push($urandom);
    repeat (30) step();
    check("t6_drained", exp_q.size(), 0);
    check("t6_deq_wrap", deq_count, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/enq_pkt_desc_deq.md
# enq_pkt_desc_deq

Dequeue stage for the enqueue packet-descriptor FIFO (`sfifo_ram_enq_pkt_desc`). It pops descriptors from the FIFO and absorbs the FIFO's one-cycle registered read latency. Popped descriptors land in a 4-entry output buffer, which presents them to the downstream scheduler on a valid/ready interface at full throughput. It also provides a dequeue-enable gate and a dequeued-descriptor counter for diagnostics.

## Interface
Parameters:
- `CNT_NBITS`, default 32: width of the dequeued-descriptor counter.

Ports:
- `clk`  in  1  clock; single clock domain.
- `` `RESET_SIG ``  in  1  reset from `defines.vh`; asynchronous, active-high.
- `deq_en`  in  1  enables new FIFO pops; does not block draining of the output buffer.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_dout`  in  enq_pkt_desc_type  FIFO read data; `meta_package` struct.
- `fifo_rd`  out  1  FIFO pop strobe.
- `desc_valid`  out  1  output descriptor valid.
- `desc`  out  enq_pkt_desc_type  output descriptor; buffer head.
- `desc_ready`  in  1  downstream accepts `desc` when `desc_valid & desc_ready`.
- `buf_count`  out  3  output-buffer occupancy, 0..4.
- `deq_count`  out  CNT_NBITS  total descriptors captured since reset.

## Operation
FIFO read contract:
- `fifo_rd` asserted in cycle t pops the head.
- `fifo_dout` in cycle t+1 holds that entry.
- Consecutive pops yield consecutive entries on consecutive cycles.

Pop rule:
- `fifo_rd = deq_en & ~fifo_empty & (buf_count + pend < 4)`, all terms combinational from registered state.
- `pend` is a 1-bit register, equal to `fifo_rd` of the previous cycle.
- The rule conservatively ignores a same-cycle pop from the buffer.
- `fifo_rd` is never asserted while `fifo_empty=1`.

Capture:
- When `pend=1`, write `fifo_dout` into the buffer at `wptr`.
- Increment `wptr` (2-bit, wraps 3 to 0).
- Increment `deq_count`, modulo 2^CNT_NBITS, silent wrap.

Output:
- `desc_valid = (buf_count != 0)`.
- `desc = buf[rptr]`.
- On handshake, increment `rptr` (2-bit wrap).

Occupancy:
- `buf_count` next value = `buf_count + pend - (desc_valid & desc_ready)`.
- Simultaneous capture and pop leaves the count unchanged.
- Capture into an empty buffer with `desc_ready=1` in the same cycle: the pop term is 0 because `desc_valid` was 0, so the count becomes 1.
- The buffer can never overflow: the pop rule guarantees `buf_count + pend ≤ 4`.

Other rules:
- `deq_en` deassert: no new `fifo_rd` from that cycle. A pop already issued (`pend=1`) is still captured. Buffered entries continue draining.
- No drop, duplication or reordering under any `desc_ready` pattern.
- Buffer storage is a flop array. Data is not reset and may be X until written. `desc` is X-free whenever `desc_valid=1`.

## Timing
Reset values: `fifo_rd=0`, `desc_valid=0`, `buf_count=0`, `deq_count=0`, `pend=0`, `wptr=rptr=0`.

Reset asserted mid-operation:
- All state clears immediately (asynchronous).
- An in-flight pop is discarded.
- The FIFO is reset by the same signal, so pointers stay consistent.

Latency:
- `fifo_rd` at cycle t → captured at the edge ending t+1 → `desc_valid=1` at t+2.
- FIFO write at cycle t (FIFO was empty) → `fifo_empty=0` at t+1 → `fifo_rd` at t+1 → `desc_valid` at t+3.

Throughput:
- One descriptor per cycle sustained with `desc_ready=1`.
- Steady state: `buf_count=1`, `pend=1`, rule 2<4.

Backpressure:
- `desc_ready=0` from reset with a non-empty FIFO gives exactly 4 pops, then `fifo_rd` stays 0.
- `desc_valid` and `desc` stay stable while `desc_valid & ~desc_ready`.

`desc` and `desc_valid` depend only on registers; no combinational path from `desc_ready` to them. `fifo_rd` does not depend on `desc_ready`.

## Test plan
- **Single entry:** write descriptor D0 to an empty FIFO at cycle 0 → `fifo_rd` at 1, `desc_valid`/`desc=D0` at 3, `deq_count=1`, `buf_count` returns to 0 after the handshake.
- **Burst:** 16 descriptors preloaded, `desc_ready=1` → `fifo_rd` high 16 consecutive cycles, `desc_valid` high 16 consecutive cycles in order, `deq_count=16`.
- **Backpressure:** 10 preloaded, `desc_ready=0` for 20 cycles → exactly 4 pops, `buf_count=4`, `desc` stable = D0. Then `desc_ready=1` → remaining 6 popped, all 10 delivered in order.
- **Random `desc_ready` and `deq_en` toggling:** 1000 descriptors through a scoreboard → no loss/reorder, `fifo_rd` never with `fifo_empty=1`, `buf_count ≤ 4`.
- **Reset mid-stream:** assert reset while `pend=1` and `buf_count=3` → outputs at reset values immediately. After release with a refilled FIFO, first `desc` is the new head.
- **Counter wrap:** `CNT_NBITS=4`, deliver 17 descriptors → `deq_count=1`.
